// File: rtl/bitop_fifo_pkg.sv
// Shared definitions for the bitop FIFO unit: register map, operation encoding
// and the bitwise operation itself.
package bitop_fifo_pkg;

   localparam logic [2:0] ADDR_A_FULL  = 3'd0;
   localparam logic [2:0] ADDR_B_FULL  = 3'd1;
   localparam logic [2:0] ADDR_Y_VALID = 3'd2;
   localparam logic [2:0] ADDR_Y_DATA  = 3'd3;
   localparam logic [2:0] ADDR_PUSH_A  = 3'd4;
   localparam logic [2:0] ADDR_PUSH_B  = 3'd5;
   localparam logic [2:0] ADDR_CTRL    = 3'd6;

   localparam int FIFO_A = 0;
   localparam int FIFO_B = 1;
   localparam int FIFO_Y = 2;

   typedef enum logic [1:0] {
      OP_AND  = 2'd0,
      OP_OR   = 2'd1,
      OP_XOR  = 2'd2,
      OP_NAND = 2'd3
   } mode_e;

   // Operates on the widest legal operand; callers truncate to their width.
   function automatic logic [31:0] apply_op(mode_e mode, logic [31:0] a, logic [31:0] b);
      logic [31:0] res;
      case (mode)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         default: res = ~(a & b);
      endcase
      return res;
   endfunction

endpackage

// File: rtl/bitop_fifo_unit_sync_fifo.sv
// Single-clock FIFO with combinational head output and occupancy count.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr_reg];

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

endmodule

// File: rtl/bitop_fifo_unit.sv
// Address-mapped two-operand bitwise unit: host fills A/B FIFOs, a compute
// stage combines their heads into the Y FIFO, and the host drains Y.
module bitop_fifo_unit
   import bitop_fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [2:0]       write_address,
   input  logic [WIDTH-1:0] write_data,
   input  logic             write_en,
   output logic             write_rdy,
   input  logic [2:0]       read_address,
   input  logic             read_en,
   output logic [WIDTH-1:0] read_data,
   output logic             read_rdy,
   output logic [CW-1:0]    a_count,
   output logic [CW-1:0]    b_count,
   output logic [CW-1:0]    y_count
);

   logic [WIDTH-1:0] fifo_din   [3];
   logic [WIDTH-1:0] fifo_dout  [3];
   logic [CW-1:0]    fifo_count [3];
   logic [2:0]       fifo_push;
   logic [2:0]       fifo_pop;
   logic [2:0]       fifo_full;
   logic [2:0]       fifo_empty;

   mode_e       mode_reg, mode_next;
   logic        err_reg, err_next;
   logic        fire;
   logic        err_set;
   logic [31:0] rd_word;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
         sync_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .CW    (CW)
         ) u_fifo (
            .clk   (CLK),
            .srst  (RST),
            .push  (fifo_push[gi]),
            .din   (fifo_din[gi]),
            .pop   (fifo_pop[gi]),
            .dout  (fifo_dout[gi]),
            .full  (fifo_full[gi]),
            .empty (fifo_empty[gi]),
            .count (fifo_count[gi])
         );
      end
   endgenerate

   assign a_count = fifo_count[FIFO_A];
   assign b_count = fifo_count[FIFO_B];
   assign y_count = fifo_count[FIFO_Y];

   // Compute uses only registered FIFO state, so a same-cycle host pop of Y
   // never unblocks it and host pushes are seen one cycle later.
   assign fire = !fifo_empty[FIFO_A] && !fifo_empty[FIFO_B] && !fifo_full[FIFO_Y];

   always_comb begin
      write_rdy = 1'b1;
      if (write_address == ADDR_PUSH_A) write_rdy = !fifo_full[FIFO_A];
      if (write_address == ADDR_PUSH_B) write_rdy = !fifo_full[FIFO_B];
   end

   assign read_rdy = (read_address == ADDR_Y_DATA) ? !fifo_empty[FIFO_Y] : 1'b1;

   always_comb begin
      fifo_push[FIFO_A] = write_en && (write_address == ADDR_PUSH_A) && !fifo_full[FIFO_A];
      fifo_push[FIFO_B] = write_en && (write_address == ADDR_PUSH_B) && !fifo_full[FIFO_B];
      fifo_push[FIFO_Y] = fire;
      fifo_pop[FIFO_A]  = fire;
      fifo_pop[FIFO_B]  = fire;
      fifo_pop[FIFO_Y]  = read_en && (read_address == ADDR_Y_DATA) && !fifo_empty[FIFO_Y];
      fifo_din[FIFO_A]  = write_data;
      fifo_din[FIFO_B]  = write_data;
      fifo_din[FIFO_Y]  = WIDTH'(apply_op(mode_reg, 32'(fifo_dout[FIFO_A]),
                                          32'(fifo_dout[FIFO_B])));
   end

   always_comb begin
      err_set = (write_en && (write_address != ADDR_PUSH_A) &&
                 (write_address != ADDR_PUSH_B) && (write_address != ADDR_CTRL)) ||
                (read_en && (read_address == ADDR_Y_DATA) && fifo_empty[FIFO_Y]);
      err_next = err_reg;
      if (read_en && (read_address == ADDR_CTRL)) err_next = 1'b0;
      if (err_set) err_next = 1'b1;
      mode_next = mode_reg;
      if (write_en && (write_address == ADDR_CTRL)) mode_next = mode_e'(2'(write_data));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         mode_reg <= OP_OR;
         err_reg  <= 1'b0;
      end else begin
         mode_reg <= mode_next;
         err_reg  <= err_next;
      end
   end

   // An empty Y reads as zero rather than exposing stale storage.
   always_comb begin
      rd_word = '0;
      case (read_address)
         ADDR_A_FULL:  rd_word = 32'(!fifo_full[FIFO_A]);
         ADDR_B_FULL:  rd_word = 32'(!fifo_full[FIFO_B]);
         ADDR_Y_VALID: rd_word = 32'(!fifo_empty[FIFO_Y]);
         ADDR_Y_DATA:  rd_word = fifo_empty[FIFO_Y] ? 32'd0 : 32'(fifo_dout[FIFO_Y]);
         ADDR_CTRL:    rd_word = 32'({err_reg, mode_reg});
         default:      rd_word = '0;
      endcase
   end

   assign read_data = WIDTH'(rd_word);

endmodule

// File: tb/tb_bitop_fifo_unit.sv
// Directed bench for bitop_fifo_unit: scoreboard of expected Y words, checked
// with immediate assertions as the host drains the Y FIFO.
module tb_bitop_fifo_unit;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             CLK;
   logic             RST;
   logic [2:0]       write_address;
   logic [WIDTH-1:0] write_data;
   logic             write_en;
   logic             write_rdy;
   logic [2:0]       read_address;
   logic             read_en;
   logic [WIDTH-1:0] read_data;
   logic             read_rdy;
   logic [CW-1:0]    a_count;
   logic [CW-1:0]    b_count;
   logic [CW-1:0]    y_count;

   int               n_checks = 0;
   int               n_pass   = 0;
   logic [WIDTH-1:0] sb [$];
   logic [1:0]       cur_mode;

   bitop_fifo_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .write_address (write_address),
      .write_data    (write_data),
      .write_en      (write_en),
      .write_rdy     (write_rdy),
      .read_address  (read_address),
      .read_en       (read_en),
      .read_data     (read_data),
      .read_rdy      (read_rdy),
      .a_count       (a_count),
      .b_count       (b_count),
      .y_count       (y_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [WIDTH-1:0] ref_op(logic [1:0] m, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
      case (m)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic wr(input logic [2:0] addr, input logic [WIDTH-1:0] data);
      write_address = addr;
      write_data    = data;
      write_en      = 1'b1;
      @(posedge CLK); #1;
      write_en = 1'b0;
   endtask

   task automatic push_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      wr(3'd4, a);
      wr(3'd5, b);
      sb.push_back(ref_op(cur_mode, a, b));
   endtask

   task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
      read_address = addr;
      read_en      = 1'b1;
      #1;
      check(tag, 32'(read_data), exp);
      @(posedge CLK); #1;
      read_en = 1'b0;
   endtask

   task automatic peek(input logic [2:0] addr, input logic [31:0] exp, input string tag);
      read_address = addr;
      #1;
      check(tag, 32'(read_data), exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Compares the Y head against the scoreboard without advancing time.
   task automatic cmp_head(input string tag);
      logic [WIDTH-1:0] exp;
      if (sb.size() == 0) begin
         n_checks++;
         $error("FAIL %s: got unexpected Y word 0x%0h required none", tag, read_data);
      end else begin
         exp = sb.pop_front();
         check(tag, 32'(read_data), 32'(exp));
      end
   endtask

   task automatic pop_y(input string tag);
      read_address = 3'd3;
      #1;
      check({tag, "_rdy"}, 32'(read_rdy), 32'd1);
      cmp_head(tag);
      read_en = 1'b1;
      @(posedge CLK); #1;
      read_en = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 60 && sb.size() > 0; k++) begin
         read_address = 3'd3;
         #1;
         if (read_rdy) pop_y(tag);
         else idle(1);
      end
   endtask

   initial begin
      RST           = 1'b1;
      write_address = 3'd0;
      write_data    = '0;
      write_en      = 1'b0;
      read_address  = 3'd0;
      read_en       = 1'b0;
      cur_mode      = 2'd1;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;

      // Reset state
      check("rst_a_count", 32'(a_count), 32'd0);
      check("rst_b_count", 32'(b_count), 32'd0);
      check("rst_y_count", 32'(y_count), 32'd0);
      write_address = 3'd4;
      #1;
      check("rst_write_rdy", 32'(write_rdy), 32'd1);
      peek(3'd0, 32'd1, "rst_a_not_full");
      peek(3'd6, 32'd1, "rst_ctrl");
      peek(3'd3, 32'd0, "rst_y_data");
      check("rst_read_rdy3", 32'(read_rdy), 32'd0);

      // First transaction latency with default OR
      push_pair(8'hF0, 8'h3C);
      check("lat_y_count_n1", 32'(y_count), 32'd0);
      idle(1);
      check("lat_y_count_n2", 32'(y_count), 32'd1);
      pop_y("or_result");
      check("or_y_count_after", 32'(y_count), 32'd0);

      // Each remaining operation
      wr(3'd6, 8'd2); cur_mode = 2'd2;
      peek(3'd6, 32'd2, "mode_xor");
      push_pair(8'hAA, 8'h0F); idle(1); pop_y("xor_result");
      wr(3'd6, 8'd0); cur_mode = 2'd0;
      push_pair(8'hAA, 8'h0F); idle(1); pop_y("and_result");
      wr(3'd6, 8'd3); cur_mode = 2'd3;
      push_pair(8'hAA, 8'h0F); idle(1); pop_y("nand_result");

      // Fill Y, then back up A and B
      wr(3'd6, 8'd1); cur_mode = 2'd1;
      for (int i = 0; i < 8; i++) push_pair(8'($urandom), 8'($urandom));
      idle(2);
      check("full_a_count", 32'(a_count), 32'd4);
      check("full_b_count", 32'(b_count), 32'd4);
      check("full_y_count", 32'(y_count), 32'd4);
      write_address = 3'd4;
      #1;
      check("full_write_rdy_a", 32'(write_rdy), 32'd0);
      write_address = 3'd5;
      #1;
      check("full_write_rdy_b", 32'(write_rdy), 32'd0);
      peek(3'd0, 32'd0, "full_a_not_full");
      peek(3'd2, 32'd1, "full_y_valid");
      pop_y("full_pop");
      check("full_pop_y_count", 32'(y_count), 32'd3);
      check("full_pop_a_count", 32'(a_count), 32'd4);
      idle(1);
      check("refill_y_count", 32'(y_count), 32'd4);
      check("refill_a_count", 32'(a_count), 32'd3);
      drain("full_drain");
      check("full_drained_y", 32'(y_count), 32'd0);
      check("full_drained_a", 32'(a_count), 32'd0);

      // Streaming with concurrent host pushes and pops
      for (int c = 0; c < 32; c++) begin
         logic [WIDTH-1:0] a_val, b_val;
         write_address = (c % 2 == 0) ? 3'd4 : 3'd5;
         write_data    = 8'($urandom);
         write_en      = 1'b1;
         if (c % 2 == 0) a_val = write_data;
         else begin
            b_val = write_data;
            sb.push_back(ref_op(cur_mode, a_val, b_val));
         end
         read_address = 3'd3;
         #1;
         if (read_rdy) begin
            cmp_head("stream_result");
            read_en = 1'b1;
         end
         check("stream_counts_le2", 32'((a_count <= 2) && (b_count <= 2) && (y_count <= 2)), 32'd1);
         @(posedge CLK); #1;
         write_en = 1'b0;
         read_en  = 1'b0;
      end
      drain("stream_tail");
      peek(3'd6, 32'(cur_mode), "stream_no_err");

      // ERR: unmapped write, then clear by reading control
      wr(3'd7, 8'h55);
      rd(3'd6, 32'(4 | cur_mode), "err_set_unmapped");
      rd(3'd6, 32'(cur_mode), "err_cleared");
      read_address = 3'd3;
      read_en      = 1'b1;
      @(posedge CLK); #1;
      read_en = 1'b0;
      rd(3'd6, 32'(4 | cur_mode), "err_set_empty_pop");

      // Reset with partially filled FIFOs
      wr(3'd6, 8'd2); cur_mode = 2'd2;
      wr(3'd4, 8'h01); wr(3'd4, 8'h02); wr(3'd5, 8'h03); wr(3'd4, 8'h04);
      idle(1);
      check("pre_rst_a_count", 32'(a_count), 32'd2);
      check("pre_rst_y_count", 32'(y_count), 32'd1);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      sb.delete();
      cur_mode = 2'd1;
      check("midrst_a_count", 32'(a_count), 32'd0);
      check("midrst_b_count", 32'(b_count), 32'd0);
      check("midrst_y_count", 32'(y_count), 32'd0);
      peek(3'd6, 32'd1, "midrst_ctrl");
      peek(3'd3, 32'd0, "midrst_y_data");
      check("midrst_read_rdy3", 32'(read_rdy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
